cic_comb_decimator: RTL and testbench

Decimating comb section of the CIC decimation filter. It follows the 19-bit integrator chain and takes one integrator output sample per `in_valid` beat. It keeps every R-th sample and passes it through N cascaded comb (differentiator) stages with differential delay M. It emits one filtered, decimated sample per R accepted inputs, qualified by a single-cycle `out_valid` pulse.

---
 rtl/cic_comb_decimator.sv | 100 ++++++++++
 tb/tb_cic_comb_decimator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cic_comb_decimator.sv
// Decimating comb section of a CIC decimator: keep every R-th integrator sample, then N comb stages.
// Optional macro CIC_COMB_PIPE_EN registers every comb stage (latency N instead of 1).
module cic_comb_decimator #(
    parameter int WIDTH = 19,
    parameter int R     = 8,
    parameter int N     = 3,
    parameter int M     = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    logic [CW-1:0]         r_cnt;
    logic                  w_dec_stb;
    // Stage k consumes w_sin[k] when w_vld_pipe[k]; stage N's input is the final result.
    logic [N:0][WIDTH-1:0] w_sin;
    logic [N:0]            w_vld_pipe;
    logic [N-1:0][WIDTH-1:0] w_diff;

    assign w_dec_stb = in_valid && (r_cnt == CW'(R - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (in_valid)
            r_cnt <= w_dec_stb ? '0 : r_cnt + 1'b1;
    end

    assign w_sin[0]      = in;
    assign w_vld_pipe[0] = w_dec_stb;

    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            logic [M-1:0][WIDTH-1:0] r_dly;

            // Modulo-2^WIDTH difference: integrator overflow cancels here.
            assign w_diff[k] = w_sin[k] - r_dly[M-1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_dly <= '0;
                end else if (w_vld_pipe[k]) begin
                    r_dly[0] <= w_sin[k];
                    for (int j = 1; j < M; j++)
                        r_dly[j] <= r_dly[j-1];
                end
            end

`ifdef CIC_COMB_PIPE_EN
            logic [WIDTH-1:0] r_stg;
            logic             r_vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_stg <= '0;
                    r_vld <= 1'b0;
                end else begin
                    r_vld <= w_vld_pipe[k];
                    if (w_vld_pipe[k])
                        r_stg <= w_diff[k];
                end
            end

            assign w_sin[k+1]      = r_stg;
            assign w_vld_pipe[k+1] = r_vld;
`else
            assign w_sin[k+1]      = w_diff[k];
            assign w_vld_pipe[k+1] = w_vld_pipe[k];
`endif
        end
    endgenerate

`ifdef CIC_COMB_PIPE_EN
    // Last stage register doubles as the output register.
    assign out       = w_sin[N];
    assign out_valid = w_vld_pipe[N];
`else
    logic [WIDTH-1:0] r_out;
    logic             r_out_vld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else begin
            r_out_vld <= w_vld_pipe[N];
            if (w_vld_pipe[N])
                r_out <= w_sin[N];
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_vld;
`endif
endmodule

// File: tb/tb_cic_comb_decimator.sv
// Directed bench for cic_comb_decimator (WIDTH=19, R=8, N=3, M=1), both latency builds.
module tb_cic_comb_decimator;
    localparam int WIDTH = 19;
`ifdef CIC_COMB_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    int n_chk  = 0;
    int n_fail = 0;
    int ncyc   = 0;
    int hold_viol = 0;
    int b2b_viol  = 0;
    logic [WIDTH-1:0] prev_out = '0;
    logic             prev_vld = 1'b0;
    logic [WIDTH-1:0] q_val[$];
    int               q_cyc[$];
    logic [WIDTH-1:0] exp_v[5];

    cic_comb_decimator #(.WIDTH(WIDTH), .R(8), .N(3), .M(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in(din),
        .out(out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, capture outputs at the following negedge.
    task automatic cyc(input logic v, input logic [WIDTH-1:0] d);
        in_valid = v;
        din      = d;
        @(negedge clk);
        ncyc++;
        if (out_valid) begin
            q_val.push_back(out);
            q_cyc.push_back(ncyc);
        end
        if (!rst && !out_valid && out !== prev_out) hold_viol++;
        if (out_valid && prev_vld) b2b_viol++;
        prev_out = out;
        prev_vld = out_valid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(1'b0, '0);
        rst = 1'b0;
        q_val.delete();
        q_cyc.delete();
        ncyc = 0;
        hold_viol = 0;
        b2b_viol  = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b1;
        din = WIDTH'($urandom);
        #1;
        n_chk++;
        if (out !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: out=%h vld=%b want 0/0", out, out_valid);
        end
        do_reset();
        for (int i = 0; i < 7; i++) cyc(1'b1, 19'd100);
        for (int i = 0; i < LAT + 2; i++) cyc(1'b0, 19'd100);
        n_chk++;
        if (q_val.size() !== 0) begin
            n_fail++;
            $display("FAIL reset_7beats: pulses=%0d want 0", q_val.size());
        end
    endtask

    task automatic test_step();
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1'b1, 19'd100);
        for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 19'd100);
        exp_v = '{19'd100, 19'h7FF38, 19'd100, 19'd0, 19'd0};
        n_chk++;
        if (q_val.size() !== 5) begin
            n_fail++;
            $display("FAIL step_count: pulses=%0d want 5", q_val.size());
        end
        for (int k = 0; k < 5 && k < q_val.size(); k++) begin
            n_chk++;
            if (q_val[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL step_val[%0d]: got %h want %h", k, q_val[k], exp_v[k]);
            end
            n_chk++;
            if (q_cyc[k] !== 8 * (k + 1) + LAT - 1) begin
                n_fail++;
                $display("FAIL step_cyc[%0d]: got %0d want %0d", k, q_cyc[k], 8 * (k + 1) + LAT - 1);
            end
        end
        n_chk++;
        if (hold_viol !== 0 || b2b_viol !== 0) begin
            n_fail++;
            $display("FAIL step_hold: hold=%0d b2b=%0d want 0/0", hold_viol, b2b_viol);
        end
    endtask

    task automatic test_ramp();
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1'b1, WIDTH'(i));
        for (int i = 0; i < LAT + 1; i++) cyc(1'b0, '0);
        exp_v = '{19'd7, 19'h7FFFA, 19'h7FFFF, 19'd0, 19'd0};
        n_chk++;
        if (q_val.size() !== 5) begin
            n_fail++;
            $display("FAIL ramp_count: pulses=%0d want 5", q_val.size());
        end
        for (int k = 0; k < 5 && k < q_val.size(); k++) begin
            n_chk++;
            if (q_val[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL ramp_val[%0d]: got %h want %h", k, q_val[k], exp_v[k]);
            end
        end
    endtask

    task automatic test_gapped();
        int i;
        int budget;
        logic v;
        i = 0;
        budget = 0;
        do_reset();
        while (i < 40 && budget < 400) begin
            v = 1'($urandom);
            cyc(v, v ? WIDTH'(i) : WIDTH'($urandom));
            if (v) i++;
            budget++;
        end
        n_chk++;
        if (i !== 40) begin
            n_fail++;
            $display("FAIL gap_budget: beats=%0d want 40", i);
        end
        for (int j = 0; j < LAT + 1; j++) cyc(1'b0, WIDTH'($urandom));
        exp_v = '{19'd7, 19'h7FFFA, 19'h7FFFF, 19'd0, 19'd0};
        n_chk++;
        if (q_val.size() !== 5) begin
            n_fail++;
            $display("FAIL gap_count: pulses=%0d want 5", q_val.size());
        end
        for (int k = 0; k < 5 && k < q_val.size(); k++) begin
            n_chk++;
            if (q_val[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL gap_val[%0d]: got %h want %h", k, q_val[k], exp_v[k]);
            end
        end
        n_chk++;
        if (hold_viol !== 0) begin
            n_fail++;
            $display("FAIL gap_hold: out changed %0d times without out_valid, want 0", hold_viol);
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] xs[3];
        logic [WIDTH-1:0] ex[3];
        xs = '{19'h7FFF8, 19'h00000, 19'h00008};
        // Unwrapped reference -8,0,8 gives s3 = -8, 24, -16.
        ex = '{19'h7FFF8, 19'h00018, 19'h7FFF0};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 7; i++) cyc(1'b1, WIDTH'($urandom));
            cyc(1'b1, xs[s]);
        end
        for (int i = 0; i < LAT + 1; i++) cyc(1'b0, '0);
        n_chk++;
        if (q_val.size() !== 3) begin
            n_fail++;
            $display("FAIL wrap_count: pulses=%0d want 3", q_val.size());
        end
        for (int k = 0; k < 3 && k < q_val.size(); k++) begin
            n_chk++;
            if (q_val[k] !== ex[k]) begin
                n_fail++;
                $display("FAIL wrap_val[%0d]: got %h want %h", k, q_val[k], ex[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 19'd100);
        for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 19'd100);
        for (int i = 0; i < 5; i++) cyc(1'b1, 19'd100);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (out !== '0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_async_clear: out=%h vld=%b want 0/0", out, out_valid);
        end
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 40; i++) cyc(1'b1, 19'd100);
        for (int i = 0; i < LAT + 1; i++) cyc(1'b0, 19'd100);
        exp_v = '{19'd100, 19'h7FF38, 19'd100, 19'd0, 19'd0};
        n_chk++;
        if (q_val.size() !== 5) begin
            n_fail++;
            $display("FAIL mid_count: pulses=%0d want 5", q_val.size());
        end
        for (int k = 0; k < 5 && k < q_val.size(); k++) begin
            n_chk++;
            if (q_val[k] !== exp_v[k]) begin
                n_fail++;
                $display("FAIL mid_val[%0d]: got %h want %h", k, q_val[k], exp_v[k]);
            end
        end
        if (q_cyc.size() > 0) begin
            n_chk++;
            if (q_cyc[0] !== 8 + LAT - 1) begin
                n_fail++;
                $display("FAIL mid_first_cyc: got %0d want %0d", q_cyc[0], 8 + LAT - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_ramp();
        test_gapped();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
